uart_rx_buffer: RTL

Serial receive front end for the memory-mapped device block. It synchronises the board `rx` pin, deserialises 8N1 UART frames, and queues received bytes in a small FIFO that the device's bus-read logic pops. Framing and overrun errors are latched as sticky flags for the device status register. It sits between the top-level `rx` pin and the device's register file, on the CPU's clock domain.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 47 ++++
 rtl/uart_rx_buffer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, frame constants and baud divider helpers
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS = 8;

  function automatic int baud_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int baud_half(input int clk_freq, input int baud_rate);
    return baud_div(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word fall-through FIFO with wrap-bit pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the head slot, so a push at full still lands.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - 8N1 UART receiver with byte FIFO and sticky error flags
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 270000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          pop,
  input  logic                          clear_err,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int DIV  = baud_div(CLK_FREQ, BAUD_RATE);
  localparam int HALF = baud_half(CLK_FREQ, BAUD_RATE);
  localparam int TW   = $clog2(DIV);
  localparam int IW   = $clog2(DATA_BITS);
  localparam logic [TW-1:0] DIV_M1   = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(HALF - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rx_s;
  rx_state_t            state;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 expire;
  logic                 push;
  logic                 frame_set;
  logic                 overrun_set;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end
  assign rx_s = sync_q[1];

  assign expire      = (timer == '0);
  assign push        = (state == RX_STOP) && expire && rx_s;
  assign frame_set   = (state == RX_STOP) && expire && !rx_s;
  assign overrun_set = push && full && !pop;

  // STOP returns to IDLE mid-stop-bit so the next start edge is never missed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RX_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state <= RX_START;
            timer <= HALF_M1;
          end
        end
        RX_START: begin
          if (expire) begin
            if (!rx_s) begin
              state   <= RX_DATA;
              timer   <= DIV_M1;
              bit_idx <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        RX_DATA: begin
          if (expire) begin
            shift[bit_idx] <= rx_s;
            timer          <= DIV_M1;
            bit_idx        <= bit_idx + IW'(1);
            if (bit_idx == LAST_BIT) state <= RX_STOP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        RX_STOP: begin
          if (expire) state <= RX_IDLE;
          else        timer <= timer - TW'(1);
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // A new error event in the same cycle as clear_err keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_set   | (frame_err & ~clear_err);
      overrun   <= overrun_set | (overrun   & ~clear_err);
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (shift),
    .pop       (pop),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .count     (count)
  );

endmodule
